io_wait_request: RTL and testbench

- Requester end of the Z80 WAIT protocol.
- Watches the Z80 bus for an I/O or memory cycle addressed to a slow device (qualified by an external select), then drives the active-low `nextwait` request into `wait_control` to stretch the cycle.
- Stretch length is a fixed number of T-states, optionally extended until the device reports ready.
- Used in front of slow peripherals (VDP, PSG, cartridge I/O) on the VG8020 board.

---
 rtl/io_wait_request.sv | 141 ++++++++++++++
 tb/tb_io_wait_request.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_wait_request.sv
// Requester end of the Z80 WAIT protocol.
// Detects a selected I/O or memory read/write cycle and holds the active-low
// nextwait request for WAIT_CYCLES T-states. With USE_READY set, the request
// is then held until the device reports ready, bounded by TIMEOUT T-states in
// total. Each bus cycle yields at most one stretch. All outputs are registered.
module io_wait_request #(
  parameter int unsigned WAIT_CYCLES = 2,    // 0..255, 0 disables the block
  parameter bit          USE_READY   = 1'b0, // extend the stretch until ready=1
  parameter int unsigned TIMEOUT     = 255   // 1..255, >= WAIT_CYCLES
) (
  input  logic clk,
  input  logic nreset,
  input  logic nm1,
  input  logic niorq,
  input  logic nmreq,
  input  logic nrd,
  input  logic nwr,
  input  logic sel,
  input  logic ready,
  output logic nextwait,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam bit Enabled = (WAIT_CYCLES != 0);

  // Counters are preloaded with N-1 so that the release happens on the posedge
  // that finds them at zero, giving exactly N low periods.
  localparam logic [7:0] CntInit   = Enabled ? 8'(WAIT_CYCLES - 1) : 8'd0;
  localparam logic [7:0] TimerInit = 8'(TIMEOUT - 1);

  state_e     state;
  logic [7:0] cnt;
  logic [7:0] timer;
  logic       q;

  // Qualified strobe: selected read/write, I/O (not interrupt acknowledge) or memory.
  assign q = sel & (~nrd | ~nwr) & ((~niorq & nm1) | ~nmreq);

  // Stretch sequencer with registered nextwait/busy/timeout.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= StIdle;
      cnt      <= 8'd0;
      timer    <= 8'd0;
      nextwait <= 1'b1;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (q) begin
            if (Enabled) begin
              cnt      <= CntInit;
              timer    <= TimerInit;
              nextwait <= 1'b0;
              busy     <= 1'b1;
              state    <= StWait;
            end else begin
              // Disabled block still tracks the bus cycle so it never stretches.
              state <= StDone;
            end
          end
        end

        StWait: begin
          if (!q) begin
            // Bus cycle ended early: drop the request, no timeout report.
            nextwait <= 1'b1;
            busy     <= 1'b0;
            state    <= StIdle;
          end else if (cnt == 8'd0) begin
            if (USE_READY && !ready) begin
              if (timer == 8'd0) begin
                // Only reachable with TIMEOUT == WAIT_CYCLES: the budget is
                // already spent, so force release instead of wrapping.
                nextwait <= 1'b1;
                busy     <= 1'b0;
                timeout  <= 1'b1;
                state    <= StDone;
              end else begin
                timer <= timer - 8'd1;
                state <= StReady;
              end
            end else begin
              nextwait <= 1'b1;
              busy     <= 1'b0;
              state    <= StDone;
            end
          end else begin
            // timer >= cnt here because TIMEOUT >= WAIT_CYCLES, so no wrap.
            cnt   <= cnt - 8'd1;
            timer <= timer - 8'd1;
          end
        end

        StReady: begin
          if (!q) begin
            nextwait <= 1'b1;
            busy     <= 1'b0;
            state    <= StIdle;
          end else if (ready) begin
            // Ready wins over an expiring timer on the same edge.
            nextwait <= 1'b1;
            busy     <= 1'b0;
            state    <= StDone;
          end else if (timer == 8'd0) begin
            nextwait <= 1'b1;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            state    <= StDone;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        StDone: begin
          // Re-arm only after the strobe has been seen inactive on a posedge.
          if (!q) begin
            state <= StIdle;
          end
        end

        default: begin
          state    <= StIdle;
          nextwait <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_wait_request.sv
// Self-checking bench for io_wait_request: five instances with different
// parameter sets share one randomized Z80 bus; a per-instance reference model
// predicts outputs, a driver queues expectations, a monitor compares them.
module tb_io_wait_request;

  localparam int NDut = 5;

  logic clk;
  logic nreset, nm1, niorq, nmreq, nrd, nwr, sel, ready;
  logic [NDut-1:0] nw, bz, tmo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit active;   // stretch in progress
    bit done;     // stretch served, waiting for the strobe to drop
    bit to;       // timeout pulse this cycle
    int elapsed;  // T-states since the stretch started
  } mst_t;

  typedef struct {
    logic [NDut-1:0] nw;
    logic [NDut-1:0] bz;
    logic [NDut-1:0] to;
  } exp_t;

  mst_t ms[NDut];
  exp_t exp_q[$];

  io_wait_request #(.WAIT_CYCLES(2), .USE_READY(1'b0), .TIMEOUT(255)) u_dut0 (
    .clk(clk), .nreset(nreset), .nm1(nm1), .niorq(niorq), .nmreq(nmreq), .nrd(nrd),
    .nwr(nwr), .sel(sel), .ready(ready), .nextwait(nw[0]), .busy(bz[0]), .timeout(tmo[0]));
  io_wait_request #(.WAIT_CYCLES(1), .USE_READY(1'b1), .TIMEOUT(10)) u_dut1 (
    .clk(clk), .nreset(nreset), .nm1(nm1), .niorq(niorq), .nmreq(nmreq), .nrd(nrd),
    .nwr(nwr), .sel(sel), .ready(ready), .nextwait(nw[1]), .busy(bz[1]), .timeout(tmo[1]));
  io_wait_request #(.WAIT_CYCLES(5), .USE_READY(1'b0), .TIMEOUT(255)) u_dut2 (
    .clk(clk), .nreset(nreset), .nm1(nm1), .niorq(niorq), .nmreq(nmreq), .nrd(nrd),
    .nwr(nwr), .sel(sel), .ready(ready), .nextwait(nw[2]), .busy(bz[2]), .timeout(tmo[2]));
  io_wait_request #(.WAIT_CYCLES(0), .USE_READY(1'b0), .TIMEOUT(255)) u_dut3 (
    .clk(clk), .nreset(nreset), .nm1(nm1), .niorq(niorq), .nmreq(nmreq), .nrd(nrd),
    .nwr(nwr), .sel(sel), .ready(ready), .nextwait(nw[3]), .busy(bz[3]), .timeout(tmo[3]));
  io_wait_request #(.WAIT_CYCLES(3), .USE_READY(1'b1), .TIMEOUT(6)) u_dut4 (
    .clk(clk), .nreset(nreset), .nm1(nm1), .niorq(niorq), .nmreq(nmreq), .nrd(nrd),
    .nwr(nwr), .sel(sel), .ready(ready), .nextwait(nw[4]), .busy(bz[4]), .timeout(tmo[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 5;
      3: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit ur_of(input int i);
    return (i == 1 || i == 4);
  endfunction

  function automatic int tmo_of(input int i);
    case (i)
      1: return 10;
      4: return 6;
      default: return 255;
    endcase
  endfunction

  function automatic mst_t mreset();
    mst_t s;
    s.active = 1'b0;
    s.done = 1'b0;
    s.to = 1'b0;
    s.elapsed = 0;
    return s;
  endfunction

  // Stretch rules in terms of elapsed T-states since the starting posedge.
  function automatic mst_t mstep(input mst_t s, input int i, input bit q, input bit rdy);
    mst_t n;
    n = s;
    n.to = 1'b0;
    if (s.active) begin
      n.elapsed = s.elapsed + 1;
      if (!q) begin
        n.active = 1'b0;
      end else if (n.elapsed >= wc_of(i) && (!ur_of(i) || rdy)) begin
        n.active = 1'b0;
        n.done = 1'b1;
      end else if (n.elapsed >= tmo_of(i)) begin
        n.active = 1'b0;
        n.done = 1'b1;
        n.to = 1'b1;
      end
    end else if (s.done) begin
      if (!q) n.done = 1'b0;
    end else if (q) begin
      if (wc_of(i) > 0) begin
        n.active = 1'b1;
        n.elapsed = 0;
      end else begin
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {nextwait,busy,timeout}=%b expected %b at %0t", name, act, exp,
               $time);
    end
  endtask

  // 0 idle, 1 io rd, 2 io wr, 3 mem rd, 4 mem wr, 5 int ack, 6 M1 fetch
  task automatic set_bus(input int kind, input bit s);
    nm1 = 1'b1; niorq = 1'b1; nmreq = 1'b1; nrd = 1'b1; nwr = 1'b1;
    sel = s;
    case (kind)
      1: begin niorq = 1'b0; nrd = 1'b0; end
      2: begin niorq = 1'b0; nwr = 1'b0; end
      3: begin nmreq = 1'b0; nrd = 1'b0; end
      4: begin nmreq = 1'b0; nwr = 1'b0; end
      5: begin niorq = 1'b0; nm1 = 1'b0; nrd = 1'b0; end
      6: begin nm1 = 1'b0; nmreq = 1'b0; nrd = 1'b0; end
      default: ;
    endcase
  endtask

  // Advance one posedge, update the models from the inputs just sampled,
  // queue the expected outputs, and return 1 ns later for new stimulus.
  task automatic tick();
    exp_t e;
    bit q;
    @(posedge clk);
    q = sel && (!nrd || !nwr) && ((!niorq && nm1) || !nmreq);
    for (int i = 0; i < NDut; i++) begin
      if (!nreset) ms[i] = mreset();
      else ms[i] = mstep(ms[i], i, q, ready);
      e.nw[i] = !ms[i].active;
      e.bz[i] = ms[i].active;
      e.to[i] = ms[i].to;
    end
    exp_q.push_back(e);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: compare every DUT against the queued expectation each negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NDut; i++) begin
          check($sformatf("dut%0d", i), {nw[i], bz[i], tmo[i]}, {e.nw[i], e.bz[i], e.to[i]});
        end
      end
    end
  end

  initial begin
    exp_t e;
    for (int i = 0; i < NDut; i++) ms[i] = mreset();
    ready = 1'b0;
    nreset = 1'b0;
    // Reset held with a qualified strobe present.
    set_bus(1, 1'b1);
    ticks(3);
    nreset = 1'b1;
    ticks(6);

    // Interrupt acknowledge and unselected memory write never qualify.
    set_bus(0, 1'b0); tick();
    set_bus(5, 1'b1); ticks(5);
    set_bus(0, 1'b0); tick();
    set_bus(4, 1'b0); ticks(4);
    set_bus(0, 1'b0); tick();

    // Ready raised four clocks after the start of the stretch.
    set_bus(1, 1'b1); ticks(4);
    ready = 1'b1; ticks(3);
    ready = 1'b0;
    set_bus(0, 1'b0); tick();
    // Ready never comes: timeout path.
    set_bus(3, 1'b1); ticks(14);
    set_bus(0, 1'b0); tick();

    // Abort mid-stretch.
    set_bus(1, 1'b1); ticks(2);
    set_bus(0, 1'b0); ticks(2);

    // Asynchronous reset mid-stretch, checked between clock edges.
    set_bus(1, 1'b1); ticks(2);
    #2;
    check("pre_reset_dut2", {nw[2], bz[2], tmo[2]}, {!ms[2].active, ms[2].active, ms[2].to});
    nreset = 1'b0;
    #1;
    for (int i = 0; i < NDut; i++) begin
      check($sformatf("async_reset_dut%0d", i), {nw[i], bz[i], tmo[i]}, 3'b100);
      ms[i] = mreset();
      e.nw[i] = 1'b1;
      e.bz[i] = 1'b0;
      e.to[i] = 1'b0;
    end
    exp_q.delete(exp_q.size() - 1);
    exp_q.push_back(e);
    tick();
    nreset = 1'b1;
    set_bus(0, 1'b0); tick();

    // Randomized bus traffic.
    for (int c = 0; c < 600; c++) begin
      int len;
      int gap;
      set_bus($urandom_range(0, 6), $urandom_range(0, 3) != 0);
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        ready = ($urandom_range(0, 4) == 0);
        tick();
      end
      gap = $urandom_range(0, 2);
      set_bus(0, $urandom_range(0, 1) != 0);
      for (int k = 0; k < gap; k++) begin
        ready = ($urandom_range(0, 4) == 0);
        tick();
      end
    end

    set_bus(0, 1'b0);
    ready = 1'b0;
    ticks(3);
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
